div_unit: RTL and testbench

//  Iterative RV32M divider (DIV/DIVU/REM/REMU) in the execute stage. Takes RD1/RD2

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/div_step.sv | 31 +++
 rtl/div_unit.sv | 185 ++++++++++++++++++
 tb/tb_div_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // funct3[1:0] encoding of the divide group
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract
// the divisor magnitude, and keep the difference when it does not go negative.
// Ports:
//   rem_i  partial remainder (XLEN+1 bits, always < dvs_i)
//   quo_i  dividend/quotient shift register
//   dvs_i  divisor magnitude
//   rem_o  next partial remainder
//   quo_o  next quotient shift register (new quotient bit in bit 0)
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] rem_sh;
    logic [XLEN+1:0] diff;
    logic            ge;

    always_comb begin
        rem_sh = {rem_i, quo_i[XLEN-1]};
        diff   = rem_sh - (XLEN+2)'(dvs_i);
        ge     = (rem_sh >= (XLEN+2)'(dvs_i));
        rem_o  = (XLEN+1)'(ge ? diff : rem_sh);
        quo_o  = {quo_i[XLEN-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         abort any in-flight operation
//   start, op     request and operation (sampled only in IDLE)
//   rs1_val       dividend, rs2_val divisor, rd_addr destination
//   busy          high in CALC/FIX/DONE
//   done          one-cycle result-valid pulse
//   result        quotient or remainder, held between operations
//   wb_rd, wb_we  register-file write port address and enable
module div_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wb_rd,
    output logic            wb_we
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            sel_rem_q, sel_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wb_we_q, wb_we_d;

    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;

    logic            is_signed;
    logic            a_neg, b_neg;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Next-state, datapath and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        sel_rem_d = sel_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        wb_rd_d   = wb_rd_q;

        is_signed = ~op[0];
        a_neg     = is_signed & rs1_val[XLEN-1];
        b_neg     = is_signed & rs2_val[XLEN-1];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_rem_d = op[1];
                    wb_rd_d   = rd_addr;
                    if (rs2_val == '0) begin
                        result_d = op[1] ? rs1_val : '1;
                        state_d  = ST_DONE;
                    end else if (is_signed && rs1_val == INT_MIN && rs2_val == '1) begin
                        // Signed overflow: quotient wraps to INT_MIN, remainder 0
                        result_d = op[1] ? '0 : INT_MIN;
                        state_d  = ST_DONE;
                    end else begin
                        quo_d     = a_neg ? (~rs1_val + XLEN'(1)) : rs1_val;
                        dvs_d     = b_neg ? (~rs2_val + XLEN'(1)) : rs2_val;
                        rem_d     = '0;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = CNT_W'(XLEN);
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Quotient sign from operand signs, remainder sign from dividend
                if (sel_rem_q) begin
                    result_d = neg_rem_q ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];
                end else begin
                    result_d = neg_quo_q ? (~quo_q + XLEN'(1)) : quo_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pipeline kill: discard everything the FSM would have done this edge
        if (flush) begin
            state_d   = ST_IDLE;
            cnt_d     = cnt_q;
            rem_d     = rem_q;
            quo_d     = quo_q;
            dvs_d     = dvs_q;
            sel_rem_d = sel_rem_q;
            neg_quo_d = neg_quo_q;
            neg_rem_d = neg_rem_q;
            result_d  = result_q;
            wb_rd_d   = wb_rd_q;
        end

        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        wb_we_d = done_d && (wb_rd_d != 5'd0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            wb_rd_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            sel_rem_q <= sel_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            wb_rd_q   <= wb_rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wb_we_q   <= wb_we_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign wb_rd  = wb_rd_q;
    assign wb_we  = wb_we_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus randomized ops
// against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wb_rd;
    logic        wb_we;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wb_rd   (wb_rd),
        .wb_we   (wb_we)
    );

    // Architectural RV32M result, straight from the ISA definition
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return (o[1]) ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (o[1]) ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op in cycle 0 and observe until the cycle after done.
    // busy_ok clears if busy drops before done, stays up after it, or wb_we strays.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int done_cyc, output logic [31:0] res,
                          output logic [4:0] wrd, output logic we, output bit busy_ok);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd_addr = rd;
        done_cyc = -1;
        busy_ok  = 1'b1;
        res = 'x;
        wrd = 'x;
        we  = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start   = 1'b0;
            rs1_val = $urandom;
            rs2_val = $urandom;
            op      = 2'($urandom);
            rd_addr = 5'($urandom);
            if (done_cyc < 0) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (wb_we === 1'b1 && done !== 1'b1) busy_ok = 1'b0;
                if (done === 1'b1) begin
                    done_cyc = c;
                    res = result;
                    wrd = wb_rd;
                    we  = wb_we;
                end
            end else begin
                if (busy !== 1'b0 || done !== 1'b0 || wb_we !== 1'b0) busy_ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; start = 1'b0;
        op = 2'b00; rs1_val = '0; rs2_val = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_wb_we got=%b exp=0", wb_we); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [9]  = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10};
        logic [31:0] as  [9]  = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                                  32'd0, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [9]  = '{32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF};
        logic [31:0] exps[9]  = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd5,
                                  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        int          lats[9]  = '{34, 34, 34, 34, 1, 1, 1, 1, 1};
        int dc; logic [31:0] r; logic [4:0] wr; logic we; bit bok;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], 5'd5, dc, r, wr, we, bok);
            n_checks++; if (dc != lats[i]) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, dc, lats[i]); end
            n_checks++; if (r !== exps[i]) begin n_fail++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, exps[i]); end
            n_checks++; if (wr !== 5'd5 || we !== 1'b1) begin n_fail++; $display("FAIL dir%0d_wb got rd=%0d we=%b exp rd=5 we=1", i, wr, we); end
            n_checks++; if (!bok) begin n_fail++; $display("FAIL dir%0d_busy_profile got=bad exp=busy 1..done then 0", i); end
        end
    endtask

    task automatic test_random();
        int dc; logic [31:0] r; logic [4:0] wr; logic we; bit bok;
        logic [1:0] o; logic [31:0] a, b; logic [4:0] rd; int mode;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
            mode = int'($urandom_range(0, 7));
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) b = 32'($urandom_range(1, 20));
            else if (mode == 3) b = 32'd0 - 32'($urandom_range(1, 20));
            run_op(o, a, b, rd, dc, r, wr, we, bok);
            n_checks++; if (r !== ref_div(o, a, b)) begin n_fail++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, r, ref_div(o, a, b)); end
            n_checks++; if (dc != ref_latency(o, a, b)) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, dc, ref_latency(o, a, b)); end
            n_checks++; if (wr !== rd || we !== (rd != 5'd0)) begin n_fail++; $display("FAIL rnd%0d_wb got rd=%0d we=%b exp rd=%0d we=%b", i, wr, we, rd, rd != 5'd0); end
            n_checks++; if (!bok) begin n_fail++; $display("FAIL rnd%0d_busy_profile got=bad exp=busy 1..done then 0", i); end
        end
    endtask

    task automatic test_ignore_and_flush();
        int dc; bit seen_done; logic [31:0] r;
        // Op A: DIVU 1000/7 with a stray start in cycle 5
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1_val = 32'd1000; rs2_val = 32'd7; rd_addr = 5'd3;
        dc = -1;
        for (int c = 1; c <= 40 && dc < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin dc = c; r = result; end
            if (c == 5) begin start = 1'b1; op = 2'b00; rs1_val = 32'd77; rs2_val = 32'd0; rd_addr = 5'd9; end
        end
        n_checks++; if (dc != 34) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=34", dc); end
        n_checks++; if (r !== 32'd142) begin n_fail++; $display("FAIL ignore_result got=%h exp=%h", r, 32'd142); end
        n_checks++; if (wb_rd !== 5'd3) begin n_fail++; $display("FAIL ignore_wb_rd got=%0d exp=3", wb_rd); end
        // Op B: flushed in cycle 10
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1_val = 32'd12345; rs2_val = 32'd11; rd_addr = 5'd7;
        seen_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1 || wb_we === 1'b1) seen_done = 1'b1;
            if (c == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (seen_done) begin n_fail++; $display("FAIL flush_no_done got=done exp=none"); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || wb_we !== 1'b0) begin n_fail++; $display("FAIL flush_idle got busy=%b done=%b we=%b exp=0", busy, done, wb_we); end
        n_checks++; if (result !== 32'd142) begin n_fail++; $display("FAIL flush_result_kept got=%h exp=%h", result, 32'd142); end
        // Op C: start in cycle 11 is accepted, done 34 cycles later
        start = 1'b1; op = 2'b01; rs1_val = 32'd50; rs2_val = 32'd5; rd_addr = 5'd8;
        dc = -1;
        for (int c = 1; c <= 40 && dc < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin dc = c; r = result; end
        end
        n_checks++; if (dc != 34) begin n_fail++; $display("FAIL after_flush_latency got=%0d exp=34", dc); end
        n_checks++; if (r !== 32'd10) begin n_fail++; $display("FAIL after_flush_result got=%h exp=%h", r, 32'd10); end
        @(negedge clk);
    endtask

    task automatic test_rst_mid_and_rd0();
        int dc; logic [31:0] r; logic [4:0] wr; logic we; bit bok;
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1_val = 32'd999; rs2_val = 32'd4; rd_addr = 5'd12;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 20) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || wb_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl got busy=%b done=%b we=%b exp=0", busy, done, wb_we); end
        n_checks++; if (result !== 32'd0 || wb_rd !== 5'd0) begin n_fail++; $display("FAIL rst_mid_data got result=%h rd=%0d exp=0", result, wb_rd); end
        run_op(2'b01, 32'd9, 32'd3, 5'd0, dc, r, wr, we, bok);
        n_checks++; if (dc != 34) begin n_fail++; $display("FAIL rd0_latency got=%0d exp=34", dc); end
        n_checks++; if (r !== 32'd3) begin n_fail++; $display("FAIL rd0_result got=%h exp=%h", r, 32'd3); end
        n_checks++; if (we !== 1'b0 || wr !== 5'd0) begin n_fail++; $display("FAIL rd0_wb got we=%b rd=%0d exp we=0 rd=0", we, wr); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL rd0_busy_profile got=bad exp=busy 1..done then 0"); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_and_flush();
        test_rst_mid_and_rd0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
